// File: rtl/edge_detect_pkg.sv
// Shared state encoding and elaboration helpers for the multi-channel edge detector.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b11,
        WAIT0 = 2'b10
    } state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel: level synchroniser, edge FSM (optional debounce via EDGE_DEBOUNCE_EN) and Mealy ticks.
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic rise_en,
    input  logic fall_en,
    output logic tick_rise,
    output logic tick_fall,
    output logic level_q
);

    if (SYNC_STAGES < 2 || DB_CYCLES < 2) begin : g_param_check
        $error("edge_detect_chan: SYNC_STAGES and DB_CYCLES must both be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    state_t                 state_r;
    state_t                 state_s;
    logic                   rise_det_s;
    logic                   fall_det_s;

    // Synchroniser chain for the asynchronous level input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], level};
        end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int CNT_W = (clog2(DB_CYCLES) < 1) ? 1 : clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    // State and stability counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ZERO;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Debounce next-state: an edge is accepted only after s holds for DB_CYCLES cycles
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        rise_det_s = 1'b0;
        fall_det_s = 1'b0;
        case (state_r)
            ZERO: begin
                if (s_s) begin
                    state_s = WAIT1;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ZERO;
                end
            end
            WAIT1: begin
                if (!s_s) begin
                    state_s = ZERO;
                end else if (cnt_r == CNT_MAX) begin
                    state_s    = ONE;
                    rise_det_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ONE: begin
                if (!s_s) begin
                    state_s = WAIT0;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ONE;
                end
            end
            WAIT0: begin
                if (s_s) begin
                    state_s = ONE;
                end else if (cnt_r == CNT_MAX) begin
                    state_s    = ZERO;
                    fall_det_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ZERO;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end
`else
    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ZERO;
        end else begin
            state_r <= state_s;
        end
    end

    // Two-state next-state: any change of s is an edge
    always_comb begin
        state_s    = state_r;
        rise_det_s = 1'b0;
        fall_det_s = 1'b0;
        case (state_r)
            ZERO: begin
                if (s_s) begin
                    state_s    = ONE;
                    rise_det_s = 1'b1;
                end else begin
                    state_s = ZERO;
                end
            end
            ONE: begin
                if (!s_s) begin
                    state_s    = ZERO;
                    fall_det_s = 1'b1;
                end else begin
                    state_s = ONE;
                end
            end
            default: begin
                state_s = ZERO;
            end
        endcase
    end
`endif

    // Enables gate only the ticks, never the state tracking
    assign tick_rise = rise_det_s & rise_en;
    assign tick_fall = fall_det_s & fall_en;
    assign level_q   = (state_r == ONE) || (state_r == WAIT0);

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector top; debounce is enabled by defining EDGE_DEBOUNCE_EN.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] level,
    input  logic [CH-1:0] rise_en,
    input  logic [CH-1:0] fall_en,
    output logic [CH-1:0] tick_rise,
    output logic [CH-1:0] tick_fall,
    output logic          any_tick,
    output logic [CH-1:0] level_q
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_detect_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .level     (level[i]),
            .rise_en   (rise_en[i]),
            .fall_en   (fall_en[i]),
            .tick_rise (tick_rise[i]),
            .tick_fall (tick_fall[i]),
            .level_q   (level_q[i])
        );
    end

    assign any_tick = |{tick_rise, tick_fall};

endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench for edge_detect_multi: stimulus queues expected ticks, a monitor checks them.
module tb_edge_detect_multi;

    localparam int CH          = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 16;
`ifdef EDGE_DEBOUNCE_EN
    localparam int LAT = SYNC_STAGES + DB_CYCLES;
`else
    localparam int LAT = SYNC_STAGES;
`endif

    logic          clk;
    logic          reset;
    logic [CH-1:0] level;
    logic [CH-1:0] rise_en;
    logic [CH-1:0] fall_en;
    logic [CH-1:0] tick_rise;
    logic [CH-1:0] tick_fall;
    logic          any_tick;
    logic [CH-1:0] level_q;

    typedef struct {
        int            cyc;
        logic [CH-1:0] r;
        logic [CH-1:0] f;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;

    edge_detect_multi #(
        .CH          (CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .level     (level),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .any_tick  (any_tick),
        .level_q   (level_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int dt, input logic [CH-1:0] r, input logic [CH-1:0] f);
        exp_t e;
        e.cyc = cyc + dt;
        e.r   = r;
        e.f   = f;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with a tick consumes one scoreboard entry
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_tick: no tick observed, expected rise=0x%0h fall=0x%0h at cycle %0d",
                         q[0].r, q[0].f, q[0].cyc);
                void'(q.pop_front());
            end
            if (any_tick || (|tick_rise) || (|tick_fall)) begin
                check("any_tick_or", {31'd0, any_tick}, {31'd0, (|tick_rise) | (|tick_fall)});
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: rise=0x%0h fall=0x%0h at cycle %0d, expected none",
                             tick_rise, tick_fall, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("tick_cycle", cyc, e.cyc);
                    check("tick_rise", {24'd0, tick_rise}, {24'd0, e.r});
                    check("tick_fall", {24'd0, tick_fall}, {24'd0, e.f});
                end
            end
        end
    end

    initial begin
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        level   = 8'h00;
        rise_en = 8'hFF;
        fall_en = 8'hFF;

        // Reset state
        wait_cyc(3);
        check("reset_tick_rise", {24'd0, tick_rise}, 32'd0);
        check("reset_tick_fall", {24'd0, tick_fall}, 32'd0);
        check("reset_any_tick", {31'd0, any_tick}, 32'd0);
        check("reset_level_q", {24'd0, level_q}, 32'd0);
        reset = 1'b0;
        wait_cyc(2);

        // Clean rise on ch0
        level[0] = 1'b1;
        push_exp(LAT, 8'h01, 8'h00);
        wait_cyc(LAT + 3);
        check("ch0_level_q", {31'd0, level_q[0]}, 32'd1);

        // ch3: rise disabled, fall enabled
        rise_en[3] = 1'b0;
        level[3]   = 1'b1;
        wait_cyc(LAT + 3);
        check("ch3_level_q_high", {31'd0, level_q[3]}, 32'd1);
        level[3] = 1'b0;
        push_exp(LAT, 8'h00, 8'h08);
        wait_cyc(LAT + 3);
        check("ch3_level_q_low", {31'd0, level_q[3]}, 32'd0);
        rise_en[3] = 1'b1;
        wait_cyc(3);

        // Simultaneous rise on ch2 and ch5
        level[2] = 1'b1;
        level[5] = 1'b1;
        push_exp(LAT, 8'h24, 8'h00);
        wait_cyc(LAT + 3);
        check("ch2_ch5_level_q", {24'd0, level_q}, 32'h25);

        // 10-cycle glitch on ch1: filtered with debounce, two ticks without
        level[1] = 1'b1;
`ifndef EDGE_DEBOUNCE_EN
        push_exp(LAT, 8'h02, 8'h00);
        push_exp(LAT + 10, 8'h00, 8'h02);
`endif
        wait_cyc(10);
        level[1] = 1'b0;
        wait_cyc(LAT + 4);
        check("ch1_glitch_level_q", {31'd0, level_q[1]}, 32'd0);

        // 40-cycle high on ch1 is accepted
        level[1] = 1'b1;
        push_exp(LAT, 8'h02, 8'h00);
        wait_cyc(40);
        check("ch1_level_q", {31'd0, level_q[1]}, 32'd1);

        // Drop all channels together
        level = 8'h00;
        push_exp(LAT, 8'h00, 8'h27);
        wait_cyc(LAT + 3);
        check("all_low_level_q", {24'd0, level_q}, 32'd0);

        // Reset while ch4 is mid-debounce (cnt = 8 when debounce is enabled)
        level[4] = 1'b1;
`ifndef EDGE_DEBOUNCE_EN
        push_exp(LAT, 8'h10, 8'h00);
`endif
        wait_cyc(SYNC_STAGES + 9);
        level[4] = 1'b0;
        reset    = 1'b1;
        #1;
        check("midrst_tick_rise", {24'd0, tick_rise}, 32'd0);
        check("midrst_tick_fall", {24'd0, tick_fall}, 32'd0);
        check("midrst_any_tick", {31'd0, any_tick}, 32'd0);
        check("midrst_level_q", {24'd0, level_q}, 32'd0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(LAT + 10);
        check("post_rst_level_q", {24'd0, level_q}, 32'd0);

        // Level held high through reset release: one rise per channel
        reset = 1'b1;
        level = 8'hFF;
        wait_cyc(3);
        reset = 1'b0;
        push_exp(LAT, 8'hFF, 8'h00);
        wait_cyc(LAT + 10);
        check("all_high_level_q", {24'd0, level_q}, 32'hFF);

        check("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
